// File: rtl/dma_read_burst_ctrl_if.sv
// DMA read command/data channel plus the outbound FWFT stream toward the SA buffers.
// The master side is the burst controller; the slave side is the DMA engine and the sink.
interface dma_read_burst_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rd_start_dma;
  logic [ADDR_W-1:0] rd_start_addr;
  logic [7:0]        rd_num_trans;
  logic              rd_done;
  logic [DATA_W-1:0] rd_data;
  logic              rd_data_vld;
  logic [DATA_W-1:0] out_data;
  logic              out_vld;
  logic              out_rdy;

  modport master (
    output rd_start_dma, rd_start_addr, rd_num_trans,
    input  rd_done, rd_data, rd_data_vld,
    output out_data, out_vld,
    input  out_rdy
  );

  modport slave (
    input  rd_start_dma, rd_start_addr, rd_num_trans,
    output rd_done, rd_data, rd_data_vld,
    input  out_data, out_vld,
    output out_rdy
  );
endinterface

// File: rtl/dma_read_burst_ctrl.sv
// Splits a host read request into bursts of up to MAX_BURST beats, one in flight at a
// time, and buffers returned beats in a FWFT FIFO that drains over valid/ready.
module dma_read_burst_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_BURST   = 16,
  parameter int FIFO_DEPTH  = 32,
  parameter int ADDR_STRIDE = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [15:0]       total_words,
  output logic              busy,
  output logic              done,
  output logic              err,
  dma_read_burst_ctrl_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FIN} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
  } cmd_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cur_addr;
  logic [15:0]       remaining;
  cmd_t              cmd;
  logic              cmd_vld;
  logic [8:0]        beat_cnt;
  logic              err_q;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  logic [7:0]        len8;
  logic [CNT_W-1:0]  free;
  logic              space_ok, issue, start_acc;
  logic [8:0]        beats_now;
  logic              full, push_req, push, pop;
  logic              burst_err, stray_err, ovf_err;

  assign len8      = (remaining > 16'(MAX_BURST)) ? 8'(MAX_BURST) : remaining[7:0];
  assign free      = CNT_W'(FIFO_DEPTH) - count;
  assign space_ok  = 16'(free) >= 16'(len8);
  assign start_acc = (state == IDLE) && start;

  // The beat landing with rd_done still belongs to this burst.
  assign beats_now = beat_cnt + {8'd0, bus.rd_data_vld};

  assign full      = count == CNT_W'(FIFO_DEPTH);
  assign pop       = bus.out_vld && bus.out_rdy;
  assign push_req  = bus.rd_data_vld && (state == WAIT);
  assign push      = push_req && (!full || pop);

  assign burst_err = (state == WAIT) && bus.rd_done && (beats_now != {1'b0, cmd.len});
  assign stray_err = (bus.rd_data_vld || bus.rd_done) && (state != WAIT);
  assign ovf_err   = push_req && full && !pop;

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = (total_words != 16'd0) ? ISSUE : FIN;
      ISSUE: if (space_ok) begin
               issue    = 1'b1;
               state_nx = WAIT;
             end
      WAIT:  if (bus.rd_done) state_nx = (remaining == 16'(cmd.len)) ? FIN : ISSUE;
      FIN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cur_addr  <= '0;
      remaining <= '0;
      cmd       <= '0;
      cmd_vld   <= 1'b0;
      beat_cnt  <= '0;
      err_q     <= 1'b0;
    end else begin
      cmd_vld <= issue;
      if (start_acc) begin
        cur_addr  <= base_addr;
        remaining <= total_words;
      end
      if (issue) begin
        cmd      <= '{addr: cur_addr, len: len8};
        beat_cnt <= '0;
      end else if ((state == WAIT) && bus.rd_data_vld) begin
        beat_cnt <= beat_cnt + 9'd1;
      end
      if ((state == WAIT) && bus.rd_done) begin
        remaining <= remaining - 16'(cmd.len);
        cur_addr  <= cur_addr + ADDR_W'(cmd.len) * ADDR_W'(ADDR_STRIDE);
      end
      // A fresh error in the accepting cycle wins over the clear.
      if (start_acc) err_q <= 1'b0;
      if (burst_err || stray_err || ovf_err) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.rd_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign busy              = state != IDLE;
  assign done              = state == FIN;
  assign err               = err_q;
  assign bus.rd_start_dma  = cmd_vld;
  assign bus.rd_start_addr = cmd.addr;
  assign bus.rd_num_trans  = cmd.len;
  assign bus.out_vld       = count != '0;
  // Stale memory contents are masked so an empty FIFO presents zero.
  assign bus.out_data      = bus.out_vld ? mem[rd_ptr] : '0;
endmodule
